// File: rtl/card_pkg.sv
// ---------------------------------------------------------------------------
// card_pkg
// Shared definitions for the baccarat hand datapath: card/score width, the
// rank codes that carry special meaning, and the rank-to-value mapping used
// by the score adders.
// ---------------------------------------------------------------------------
package card_pkg;

    localparam int CARD_W = 4;

    localparam logic [CARD_W-1:0] RANK_EMPTY = 4'd0;
    localparam logic [CARD_W-1:0] RANK_ACE   = 4'd1;
    localparam logic [CARD_W-1:0] RANK_TEN   = 4'd10;
    localparam logic [CARD_W-1:0] RANK_KING  = 4'd13;

    // Ace..9 count at face value; 10, J, Q, K and an empty slot are worth 0.
    function automatic logic [CARD_W-1:0] card_value(input logic [CARD_W-1:0] rank);
        if ((rank >= RANK_ACE) && (rank < RANK_TEN))
            return rank;
        else
            return RANK_EMPTY;
    endfunction

endpackage

// File: rtl/card_score.sv
// ---------------------------------------------------------------------------
// card_score
// Combinational baccarat hand score: (value1 + value2 + value3) mod 10.
// Ports:
//   rank1_i, rank2_i, rank3_i  raw ranks of the three hand slots (0 = empty)
//   score_o                    hand score, 0..9
// ---------------------------------------------------------------------------
module card_score
    import card_pkg::*;
(
    input  logic [CARD_W-1:0] rank1_i,
    input  logic [CARD_W-1:0] rank2_i,
    input  logic [CARD_W-1:0] rank3_i,
    output logic [CARD_W-1:0] score_o
);

    // Three values of at most 9 each: the sum never exceeds 27, so 5 bits
    // suffice and a two-step subtract replaces a general modulo.
    logic [4:0] sum_w;

    always_comb begin
        sum_w = 5'(card_value(rank1_i)) + 5'(card_value(rank2_i)) + 5'(card_value(rank3_i));
        if (sum_w >= 5'd20)
            score_o = CARD_W'(sum_w - 5'd20);
        else if (sum_w >= 5'd10)
            score_o = CARD_W'(sum_w - 5'd10);
        else
            score_o = CARD_W'(sum_w);
    end

endmodule

// File: rtl/card_datapath.sv
// ---------------------------------------------------------------------------
// card_datapath
// Hand datapath feeding the baccarat dealing/scoring state machine.
// Captures new_card into one of six hand slots on its load strobe, rejects
// illegal loads with a sticky error flag, and counts cards per hand.
// Ports:
//   slow_clock            clock, rising edge
//   resetb                asynchronous active-low reset
//   new_card              rank being dealt (1..13)
//   load_pcard1/2/3       player slot load strobes
//   load_dcard1/2/3       dealer slot load strobes
//   pcard_out1/2/3        registered player ranks (0 = empty)
//   dcard_out1/2/3        registered dealer ranks (0 = empty)
//   pscore, dscore        combinational hand scores, 0..9
//   pcard3                raw rank of player slot 3
//   pcount, dcount        filled slot counts per hand, 0..3
//   load_err              sticky illegal-load flag
// ---------------------------------------------------------------------------
module card_datapath
    import card_pkg::*;
(
    input  logic              slow_clock,
    input  logic              resetb,
    input  logic [CARD_W-1:0] new_card,
    input  logic              load_pcard1,
    input  logic              load_pcard2,
    input  logic              load_pcard3,
    input  logic              load_dcard1,
    input  logic              load_dcard2,
    input  logic              load_dcard3,
    output logic [CARD_W-1:0] pcard_out1,
    output logic [CARD_W-1:0] pcard_out2,
    output logic [CARD_W-1:0] pcard_out3,
    output logic [CARD_W-1:0] dcard_out1,
    output logic [CARD_W-1:0] dcard_out2,
    output logic [CARD_W-1:0] dcard_out3,
    output logic [CARD_W-1:0] pscore,
    output logic [CARD_W-1:0] dscore,
    output logic [CARD_W-1:0] pcard3,
    output logic [1:0]        pcount,
    output logic [1:0]        dcount,
    output logic              load_err
);

    // Slot order: 0..2 player cards 1..3, 3..5 dealer cards 1..3.
    logic [5:0]        load_vec;
    logic [CARD_W-1:0] slot_q [6];
    logic [CARD_W-1:0] slot_d [6];
    logic [1:0]        pcount_q, pcount_d;
    logic [1:0]        dcount_q, dcount_d;
    logic              err_q, err_d;

    logic              rank_ok;
    logic              single_strobe;
    logic              hit_full;
    logic              load_ok;

    assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                       load_pcard3, load_pcard2, load_pcard1};

    always_comb begin
        rank_ok       = (new_card >= RANK_ACE) && (new_card <= RANK_KING);
        single_strobe = $onehot(load_vec);

        // With exactly one strobe this flags an occupied target slot; with
        // several strobes the load is rejected regardless.
        hit_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (load_vec[i] && (slot_q[i] != RANK_EMPTY))
                hit_full = 1'b1;
        end

        load_ok = single_strobe && rank_ok && !hit_full;

        for (int i = 0; i < 6; i++) begin
            slot_d[i] = (load_ok && load_vec[i]) ? new_card : slot_q[i];
        end

        // Each slot loads at most once per hand, so counts stop at 3.
        pcount_d = pcount_q + ((load_ok && (|load_vec[2:0])) ? 2'd1 : 2'd0);
        dcount_d = dcount_q + ((load_ok && (|load_vec[5:3])) ? 2'd1 : 2'd0);

        err_d = err_q | ((|load_vec) && !load_ok);
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 6; i++) begin
                slot_q[i] <= RANK_EMPTY;
            end
            pcount_q <= 2'd0;
            dcount_q <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                slot_q[i] <= slot_d[i];
            end
            pcount_q <= pcount_d;
            dcount_q <= dcount_d;
            err_q    <= err_d;
        end
    end

    card_score u_pscore (
        .rank1_i (slot_q[0]),
        .rank2_i (slot_q[1]),
        .rank3_i (slot_q[2]),
        .score_o (pscore)
    );

    card_score u_dscore (
        .rank1_i (slot_q[3]),
        .rank2_i (slot_q[4]),
        .rank3_i (slot_q[5]),
        .score_o (dscore)
    );

    assign pcard_out1 = slot_q[0];
    assign pcard_out2 = slot_q[1];
    assign pcard_out3 = slot_q[2];
    assign dcard_out1 = slot_q[3];
    assign dcard_out2 = slot_q[4];
    assign dcard_out3 = slot_q[5];
    assign pcard3     = slot_q[2];
    assign pcount     = pcount_q;
    assign dcount     = dcount_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_card_datapath.sv
// ---------------------------------------------------------------------------
// tb_card_datapath
// Self-checking bench for card_datapath: a table of directed vectors, a
// hand-written mid-cycle reset sequence, and randomized loads compared
// against a behavioural hand model.
// ---------------------------------------------------------------------------
module tb_card_datapath;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] new_card;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] pcard_out1, pcard_out2, pcard_out3;
    logic [3:0] dcard_out1, dcard_out2, dcard_out3;
    logic [3:0] pscore, dscore, pcard3;
    logic [1:0] pcount, dcount;
    logic       load_err;

    card_datapath dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .new_card    (new_card),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .pcard_out1  (pcard_out1),
        .pcard_out2  (pcard_out2),
        .pcard_out3  (pcard_out3),
        .dcard_out1  (dcard_out1),
        .dcard_out2  (dcard_out2),
        .dcard_out3  (dcard_out3),
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3      (pcard3),
        .pcount      (pcount),
        .dcount      (dcount),
        .load_err    (load_err)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model: six slots (player 0..2, dealer 3..5), error flag.
    int m_slot [6];
    bit m_err;

    // Strobe encoding used throughout the bench.
    localparam logic [5:0] P1 = 6'b000001, P2 = 6'b000010, P3 = 6'b000100;
    localparam logic [5:0] D1 = 6'b001000, D2 = 6'b010000, D3 = 6'b100000;

    typedef struct {
        bit         rst;
        logic [5:0] ld;
        logic [3:0] card;
        int         sel;
        int         sval;
        int         ps, ds, pc, dc, err, p3;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(bit rst, logic [5:0] ld, logic [3:0] card, int sel, int sval,
                                int ps, int ds, int pc, int dc, int err, int p3);
        vec_t v;
        v.rst = rst; v.ld = ld; v.card = card; v.sel = sel; v.sval = sval;
        v.ps = ps; v.ds = ds; v.pc = pc; v.dc = dc; v.err = err; v.p3 = p3;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_slot(int s);
        case (s)
            0: return int'(pcard_out1);
            1: return int'(pcard_out2);
            2: return int'(pcard_out3);
            3: return int'(dcard_out1);
            4: return int'(dcard_out2);
            default: return int'(dcard_out3);
        endcase
    endfunction

    // Baccarat score from first principles: face value for 1..9, else 0.
    function automatic int hand_score(int a, int b, int c);
        int v [3];
        v[0] = a; v[1] = b; v[2] = c;
        for (int i = 0; i < 3; i++) if (v[i] < 1 || v[i] > 9) v[i] = 0;
        return (v[0] + v[1] + v[2]) % 10;
    endfunction

    function automatic int filled(int base);
        int n = 0;
        for (int i = base; i < base + 3; i++) if (m_slot[i] != 0) n++;
        return n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) m_slot[i] = 0;
        m_err = 1'b0;
    endfunction

    function automatic void model_step(logic [5:0] ld, int card);
        int n = 0;
        int idx = 0;
        for (int i = 0; i < 6; i++) if (ld[i]) begin n++; idx = i; end
        if (n == 0) return;
        if (n == 1 && card >= 1 && card <= 13 && m_slot[idx] == 0)
            m_slot[idx] = card;
        else
            m_err = 1'b1;
    endfunction

    task automatic drive(input logic [5:0] ld, input logic [3:0] card);
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
        new_card = card;
    endtask

    // Present one cycle of inputs, let the edge take them, sample 1 time unit later.
    task automatic step(input logic [5:0] ld, input logic [3:0] card);
        @(negedge slow_clock);
        drive(ld, card);
        @(posedge slow_clock);
        #1;
        drive(6'b0, 4'd0);
        model_step(ld, int'(card));
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        @(negedge slow_clock);
        drive(6'b0, 4'd0);
        #2 resetb = 1'b0;
        #1 resetb = 1'b1;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_slot%0d", tag, i), dut_slot(i), m_slot[i]);
        chk({tag, "_pscore"}, int'(pscore), hand_score(m_slot[0], m_slot[1], m_slot[2]));
        chk({tag, "_dscore"}, int'(dscore), hand_score(m_slot[3], m_slot[4], m_slot[5]));
        chk({tag, "_pcard3"}, int'(pcard3), m_slot[2]);
        chk({tag, "_pcount"}, int'(pcount), filled(0));
        chk({tag, "_dcount"}, int'(dcount), filled(3));
        chk({tag, "_err"}, int'(load_err), int'(m_err));
    endtask

    initial begin
        resetb = 1'b0;
        drive(6'b0, 4'd0);
        model_reset();
        repeat (2) @(posedge slow_clock);
        #1;
        check_all("reset");
        @(negedge slow_clock);
        resetb = 1'b1;

        // rst, ld, card, sel, sval, ps, ds, pc, dc, err, p3
        vt.push_back(mk(1, P1,  3, 0,  3, 3, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, D1, 12, 3, 12, 3, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, P2,  4, 1,  4, 7, 0, 2, 1, 0, 0));
        vt.push_back(mk(0, D2,  7, 4,  7, 7, 7, 2, 2, 0, 0));
        vt.push_back(mk(1, P1,  9, 0,  9, 9, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, P2,  8, 1,  8, 7, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, P3, 13, 2, 13, 7, 0, 3, 0, 0, 13));
        vt.push_back(mk(0, D1,  9, 3,  9, 7, 9, 3, 1, 0, 13));
        vt.push_back(mk(0, D2,  9, 4,  9, 7, 8, 3, 2, 0, 13));
        vt.push_back(mk(0, D3,  9, 5,  9, 7, 7, 3, 3, 0, 13));
        vt.push_back(mk(1, P1,  5, 0,  5, 5, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, P1,  2, 0,  5, 5, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, D1,  6, 3,  6, 5, 6, 1, 1, 1, 0));
        vt.push_back(mk(0, P2,  3, 1,  3, 8, 6, 2, 1, 1, 0));
        vt.push_back(mk(0, 6'b0, 5, 1, 3, 8, 6, 2, 1, 1, 0));
        vt.push_back(mk(1, P1 | D1, 6, 0, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 6'b0, 6, 3,  0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, D2, 14, 4,  0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, P1,  0, 0,  0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, D3, 15, 5,  0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, P3,  8, 2,  8, 8, 0, 1, 0, 0, 8));
        vt.push_back(mk(1, P1,  4, 0,  4, 4, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, P2,  6, 1,  6, 0, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, P3, 10, 2, 10, 0, 0, 3, 0, 0, 10));

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            step(vt[i].ld, vt[i].card);
            chk($sformatf("v%0d_slot", i), dut_slot(vt[i].sel), vt[i].sval);
            chk($sformatf("v%0d_pscore", i), int'(pscore), vt[i].ps);
            chk($sformatf("v%0d_dscore", i), int'(dscore), vt[i].ds);
            chk($sformatf("v%0d_pcount", i), int'(pcount), vt[i].pc);
            chk($sformatf("v%0d_dcount", i), int'(dcount), vt[i].dc);
            chk($sformatf("v%0d_err", i), int'(load_err), vt[i].err);
            chk($sformatf("v%0d_pcard3", i), int'(pcard3), vt[i].p3);
        end

        // Asynchronous reset mid-hand: outputs must clear before the next edge.
        do_reset();
        step(P1, 4'd1);
        step(P2, 4'd2);
        step(D1, 4'd3);
        step(D2, 4'd4);
        step(P1 | P2, 4'd5);
        check_all("prefill");
        #2 resetb = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_before_edge", int'(slow_clock), 1);
        #1 resetb = 1'b1;

        // Randomized hands against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [5:0] ld;
            logic [3:0] card;
            int r;
            if ($urandom_range(0, 29) == 0) begin
                do_reset();
                check_all($sformatf("rnd%0d_rst", n));
            end
            r = $urandom_range(0, 9);
            if (r < 7)       ld = 6'b1 << $urandom_range(0, 5);
            else if (r == 7) ld = 6'b0;
            else             ld = 6'($urandom_range(0, 63));
            card = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(1, 13));
            step(ld, card);
            check_all($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
